// File: rtl/pingpang_pkg.sv
// pingpang_pkg: shared types and defaults for the ping-pong writer.
// Optional drop counter is enabled by PINGPANG_DROP_CNT_EN.
package pingpang_pkg;

  typedef enum logic [1:0] {
    FILL_A,
    FILL_B,
    HOLD
  } pp_state_t;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

  localparam int PP_DATA_W     = 16;
  localparam int PP_BANK_DEPTH = 8;

endpackage

// File: rtl/pingpang_wr_ctrl_if.sv
// pingpang_wr_ctrl_if: upstream stream, bank write and release signals.
// drop_cnt exists only when PINGPANG_DROP_CNT_EN is defined.
interface pingpang_wr_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);

  logic              data_en;
  logic [DATA_W-1:0] data_in;
  logic              in_ready;
  logic [DATA_W-1:0] data_in_a;
  logic [DATA_W-1:0] data_in_b;
  logic              wr_en_a;
  logic              wr_en_b;
  logic [ADDR_W-1:0] wr_addr;
  logic              switch;
  logic [1:0]        bank_rdy;
  logic              rd_done_a;
  logic              rd_done_b;
  logic              ovf;
`ifdef PINGPANG_DROP_CNT_EN
  logic [15:0]       drop_cnt;

  modport slave (
    input  data_en, data_in,
    input  rd_done_a, rd_done_b,
    output in_ready,
    output data_in_a, data_in_b,
    output wr_en_a, wr_en_b,
    output wr_addr, switch,
    output bank_rdy, ovf,
    output drop_cnt
  );

  modport master (
    output data_en, data_in,
    output rd_done_a, rd_done_b,
    input  in_ready,
    input  data_in_a, data_in_b,
    input  wr_en_a, wr_en_b,
    input  wr_addr, switch,
    input  bank_rdy, ovf,
    input  drop_cnt
  );
`else
  modport slave (
    input  data_en, data_in,
    input  rd_done_a, rd_done_b,
    output in_ready,
    output data_in_a, data_in_b,
    output wr_en_a, wr_en_b,
    output wr_addr, switch,
    output bank_rdy, ovf
  );

  modport master (
    output data_en, data_in,
    output rd_done_a, rd_done_b,
    input  in_ready,
    input  data_in_a, data_in_b,
    input  wr_en_a, wr_en_b,
    input  wr_addr, switch,
    input  bank_rdy, ovf
  );
`endif

endinterface

// File: rtl/pingpang_bank_lock.sv
// pingpang_bank_lock: one bank's full/awaiting-read flag.
// Set beats clear; a release of an unlocked bank changes nothing.
module pingpang_bank_lock (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clr,
  output logic rdy
);

  // lock on fill, unlock on reader release
  always_ff @(posedge clk) begin
    if (rst)
      rdy <= 1'b0;
    else if (set)
      rdy <= 1'b1;
    else if (clr)
      rdy <= 1'b0;
  end

endmodule

// File: rtl/pingpang_wr_ctrl.sv
// pingpang_wr_ctrl: packs an upstream word stream into two banks.
// Define PINGPANG_DROP_CNT_EN to add the saturating drop_cnt output.
module pingpang_wr_ctrl
  import pingpang_pkg::*;
#(
  parameter int DATA_W     = PP_DATA_W,
  parameter int BANK_DEPTH = PP_BANK_DEPTH
) (
  input logic               clk,
  input logic               rst,
  pingpang_wr_ctrl_if.slave bus
);

  localparam int ADDR_W = $clog2(BANK_DEPTH);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(BANK_DEPTH - 1);

  pp_state_t         state, state_n;
  logic              next_bank, next_bank_n;
  logic [ADDR_W-1:0] cnt;
  logic              in_ready;
  logic              cur_bank;
  logic              accept;
  logic              drop;
  logic              last_acc;
  logic              set_a, set_b;
  logic [1:0]        rdy;

  assign in_ready = (state != HOLD);
  assign cur_bank = (state == FILL_B);
  assign accept   = bus.data_en & in_ready;
  assign drop     = bus.data_en & ~in_ready;
  assign last_acc = accept & (cnt == LAST);
  assign set_a    = last_acc & (state == FILL_A);
  assign set_b    = last_acc & (state == FILL_B);

  assign bus.in_ready = in_ready;
  assign bus.bank_rdy = rdy;

  pingpang_bank_lock u_lock_a (
    .clk (clk),
    .rst (rst),
    .set (set_a),
    .clr (bus.rd_done_a),
    .rdy (rdy[BANK_A])
  );

  pingpang_bank_lock u_lock_b (
    .clk (clk),
    .rst (rst),
    .set (set_b),
    .clr (bus.rd_done_b),
    .rdy (rdy[BANK_B])
  );

  // state and word counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL_A;
      next_bank <= BANK_A;
      cnt       <= '0;
    end else begin
      state     <= state_n;
      next_bank <= next_bank_n;
      if (accept)
        cnt <= cnt + ADDR_W'(1);
    end
  end

  // next state: swap on fill, park in HOLD if the other bank is locked
  always_comb begin
    state_n     = state;
    next_bank_n = next_bank;
    unique case (state)
      FILL_A: begin
        if (last_acc) begin
          if (!rdy[BANK_B] || bus.rd_done_b) begin
            state_n = FILL_B;
          end else begin
            state_n     = HOLD;
            next_bank_n = BANK_B;
          end
        end
      end
      FILL_B: begin
        if (last_acc) begin
          if (!rdy[BANK_A] || bus.rd_done_a) begin
            state_n = FILL_A;
          end else begin
            state_n     = HOLD;
            next_bank_n = BANK_A;
          end
        end
      end
      HOLD: begin
        if (next_bank == BANK_A && bus.rd_done_a)
          state_n = FILL_A;
        else if (next_bank == BANK_B && bus.rd_done_b)
          state_n = FILL_B;
      end
      default: state_n = FILL_A;
    endcase
  end

  // registered bank writes; switch follows the last accepted word
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.wr_en_a   <= 1'b0;
      bus.wr_en_b   <= 1'b0;
      bus.data_in_a <= '0;
      bus.data_in_b <= '0;
      bus.wr_addr   <= '0;
      bus.switch    <= BANK_A;
    end else begin
      bus.wr_en_a   <= accept & (cur_bank == BANK_A);
      bus.wr_en_b   <= accept & (cur_bank == BANK_B);
      bus.data_in_a <= (accept && cur_bank == BANK_A)
                       ? bus.data_in : '0;
      bus.data_in_b <= (accept && cur_bank == BANK_B)
                       ? bus.data_in : '0;
      if (accept) begin
        bus.wr_addr <= cnt;
        bus.switch  <= cur_bank;
      end
    end
  end

`ifdef PINGPANG_DROP_CNT_EN
  // sticky overflow flag and saturating drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ovf      <= 1'b0;
      bus.drop_cnt <= '0;
    end else if (drop) begin
      bus.ovf <= 1'b1;
      if (bus.drop_cnt != 16'hFFFF)
        bus.drop_cnt <= bus.drop_cnt + 16'd1;
    end
  end
`else
  // sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst)
      bus.ovf <= 1'b0;
    else if (drop)
      bus.ovf <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_pingpang_wr_ctrl.sv
// tb_pingpang_wr_ctrl: directed and random checks against a bank model.
// Honours PINGPANG_DROP_CNT_EN for the drop counter.
module tb_pingpang_wr_ctrl;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic clk;
  logic rst;

  pingpang_wr_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  pingpang_wr_ctrl #(
    .DATA_W     (DW),
    .BANK_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: bank being filled, words in it, lock per bank
  int          m_cur;
  int          m_cnt;
  bit          m_lock [2];
  bit          m_ovf;
  int          m_drop;
  bit          m_sw;
  bit          e_wa, e_wb;
  logic [15:0] e_da, e_db;
  int          e_addr;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    m_cur     = 0;
    m_cnt     = 0;
    m_lock[0] = 1'b0;
    m_lock[1] = 1'b0;
    m_ovf     = 1'b0;
    m_drop    = 0;
    m_sw      = 1'b0;
    e_wa      = 1'b0;
    e_wb      = 1'b0;
    e_da      = '0;
    e_db      = '0;
    e_addr    = 0;
  endtask

  task automatic cyc(input bit r, input bit en,
                     input logic [15:0] d,
                     input bit da, input bit db);
    bit ready;
    bit set [2];
    rst           = r;
    bus.data_en   = en;
    bus.data_in   = d;
    bus.rd_done_a = da;
    bus.rd_done_b = db;
    ready  = !m_lock[m_cur];
    set[0] = 1'b0;
    set[1] = 1'b0;
    @(posedge clk);
    #1;
    if (r) begin
      mdl_reset();
    end else begin
      e_wa = 1'b0;
      e_wb = 1'b0;
      e_da = '0;
      e_db = '0;
      if (en && ready) begin
        if (m_cur == 0) begin
          e_wa = 1'b1;
          e_da = d;
        end else begin
          e_wb = 1'b1;
          e_db = d;
        end
        e_addr = m_cnt;
        m_sw   = (m_cur == 1);
        m_cnt++;
        if (m_cnt == DEPTH) begin
          m_cnt       = 0;
          set[m_cur]  = 1'b1;
          m_cur       = 1 - m_cur;
        end
      end else if (en) begin
        m_ovf = 1'b1;
        if (m_drop < 65535) m_drop++;
      end
      if (set[0]) m_lock[0] = 1'b1;
      else if (da) m_lock[0] = 1'b0;
      if (set[1]) m_lock[1] = 1'b1;
      else if (db) m_lock[1] = 1'b0;
    end
    chk("in_ready", 32'(bus.in_ready),
        32'(!m_lock[m_cur]));
    chk("wr_en_a", 32'(bus.wr_en_a), 32'(e_wa));
    chk("wr_en_b", 32'(bus.wr_en_b), 32'(e_wb));
    chk("data_in_a", 32'(bus.data_in_a), 32'(e_da));
    chk("data_in_b", 32'(bus.data_in_b), 32'(e_db));
    chk("switch", 32'(bus.switch), 32'(m_sw));
    chk("bank_rdy", 32'(bus.bank_rdy),
        32'({m_lock[1], m_lock[0]}));
    chk("ovf", 32'(bus.ovf), 32'(m_ovf));
    if (e_wa || e_wb || r)
      chk("wr_addr", 32'(bus.wr_addr), 32'(e_addr));
`ifdef PINGPANG_DROP_CNT_EN
    chk("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
`endif
  endtask

  initial begin
    mdl_reset();
    rst           = 1'b1;
    bus.data_en   = 1'b0;
    bus.data_in   = '0;
    bus.rd_done_a = 1'b0;
    bus.rd_done_b = 1'b0;

    // reset held with data_en high
    for (int i = 0; i < 3; i++) cyc(1, 1, 16'hABCD, 0, 0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_wr_en_a", 32'(bus.wr_en_a), 32'd0);
    chk("rst_switch", 32'(bus.switch), 32'd0);
    chk("rst_bank_rdy", 32'(bus.bank_rdy), 32'd0);

    // continuous stream 1..8, release A with word 5
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 1, 16'(i), 0, 0);
      chk("s_addr_a", 32'(bus.wr_addr), 32'(i - 1));
    end
    chk("s_rdy_01", 32'(bus.bank_rdy), 32'b01);
    chk("s_sw_last_a", 32'(bus.switch), 32'd0);
    cyc(0, 1, 16'd5, 1, 0);
    chk("s_sw_first_b", 32'(bus.switch), 32'd1);
    chk("s_wr_b5", 32'(bus.data_in_b), 32'd5);
    for (int i = 6; i <= 8; i++) cyc(0, 1, 16'(i), 0, 0);
    chk("s_rdy_10", 32'(bus.bank_rdy), 32'b10);

    // both banks locked, drop, release A
    cyc(1, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) cyc(0, 1, 16'(i), 0, 0);
    chk("h_ready0", 32'(bus.in_ready), 32'd0);
    chk("h_rdy_11", 32'(bus.bank_rdy), 32'b11);
    cyc(0, 1, 16'd9, 0, 0);
    chk("h_ovf", 32'(bus.ovf), 32'd1);
    chk("h_no_wr", 32'({bus.wr_en_a, bus.wr_en_b}), 32'd0);
    cyc(0, 0, 0, 1, 0);
    chk("h_ready1", 32'(bus.in_ready), 32'd1);
    cyc(0, 1, 16'd10, 0, 0);
    chk("h_w10_en", 32'(bus.wr_en_a), 32'd1);
    chk("h_w10_data", 32'(bus.data_in_a), 32'd10);
    chk("h_w10_addr", 32'(bus.wr_addr), 32'd0);
    chk("h_w10_sw", 32'(bus.switch), 32'd0);

    // release of B on A's last word: no HOLD cycle
    cyc(0, 1, 16'd11, 0, 0);
    cyc(0, 1, 16'd12, 0, 0);
    cyc(0, 1, 16'd13, 0, 1);
    chk("r_ready", 32'(bus.in_ready), 32'd1);
    cyc(0, 1, 16'd14, 0, 0);
    chk("r_b_wr", 32'(bus.wr_en_b), 32'd1);
    chk("r_b_data", 32'(bus.data_in_b), 32'd14);

    // stray release
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("st_rdy", 32'(bus.bank_rdy), 32'd0);
    chk("st_ready", 32'(bus.in_ready), 32'd1);

    // reset two words into B
    for (int i = 1; i <= 6; i++) cyc(0, 1, 16'(i), 0, 0);
    chk("m_sw_b", 32'(bus.switch), 32'd1);
    cyc(1, 0, 0, 0, 0);
    chk("m_sw", 32'(bus.switch), 32'd0);
    chk("m_rdy", 32'(bus.bank_rdy), 32'd0);
    cyc(0, 1, 16'h77, 0, 0);
    chk("m_wr_a", 32'(bus.wr_en_a), 32'd1);
    chk("m_addr", 32'(bus.wr_addr), 32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 300) == 0,
          ($urandom % 4) != 0,
          16'($urandom),
          ($urandom % 6) == 0,
          ($urandom % 6) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
